fp_mul_arbiter: RTL
===================

Name: fp_mul_arbiter

Overview:
- Shares one Q5.3 unsigned fixed-point multiplier among NREQ requesters. Each operand is 8 bits: 5 integer bits and 3 fractional bits.
- Selects requesters round-robin, registers the operands, computes the rounded product, and returns it on a single response channel tagged with the requester id.
- Sits between the multiplier clients and the shared multiply datapath. Gives them exclusive, fair, handshaked access.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request pending.
- req_a  input  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*NREQ  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant/accept; the request is taken when req_valid[i] && req_ready[i].
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_result  output  8  Q5.3 product.
- busy  output  1  high in any state other than IDLE.
- op_count  output  16  count of completed responses; wraps at 16'hFFFF.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, op_count=0, busy=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation abandons the operation with no response. op_count is not incremented.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - Combinational grant g = first i with req_valid[i], searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready = one-hot(g) if any req_valid is high, otherwise 0. req_ready never asserts outside IDLE.
  - On handshake: latch a_r, b_r, id_r=g; ptr <= (g+1) mod NREQ; next state MUL.
  - With no request, stay in IDLE; ptr is unchanged.
- MUL:
  - prod = a_r * b_r as a full 16-bit unsigned value.
  - rsp_result <= prod[10:3] + prod[2], truncated to 8 bits (round half up at the 1/16 bit). Overflow wraps.
  - rsp_id <= id_r. Next state RESP.
- RESP:
  - rsp_valid=1. rsp_result and rsp_id are held stable until the handshake.
  - On rsp_ready=1: op_count <= op_count+1, rsp_valid <= 0 at the next edge, next state IDLE.
  - There is no same-cycle re-grant in RESP.
- Latency: request handshake in cycle T; rsp_valid high from cycle T+2.
- Throughput: at most 1 op per 3 cycles with rsp_ready held high.
- Fairness: a continuously requesting requester is served within NREQ grants.
- Outputs are registered except req_ready, which is combinational from req_valid, ptr and state.
- Requester operands are sampled only in the handshake cycle. Later changes do not affect the result.
- Deasserting req_valid while not granted is legal; that requester is simply skipped.

Optional Feature:
- Macro: FP_MUL_SAT_EN.
- Defined: result saturates to 8'hFF if prod[15:11] != 0, or if prod[10:3]==8'hFF and prod[2]==1. Otherwise the normal rounded value.
- Not defined: wrap-around truncation as described in Behaviour.
- Handshake, latency and op_count are identical in both builds.

Test Plan:
- Single op: req0 only, a=8'h0A (1.25), b=8'h0C (1.5) -> handshake in cycle T, rsp_valid at T+2, rsp_id=0, rsp_result=8'h0F (1.875), op_count=1.
- Rounding: a=8'h0C, b=8'h0B, prod=132 -> rsp_result=8'h11. Also a=8'h10, b=8'h50 -> 8'hA0 (20.0); a=8'h0A, b=8'h40 -> 8'h50 (10.0).
- Round-robin: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0. Each rsp_id matches its grant; spacing of 3 cycles between handshakes.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable; req_ready stays 0; no new grant until rsp_ready=1.
- Overflow: a=8'h1C, b=8'h49, prod=16'h07FC -> 8'h00 without FP_MUL_SAT_EN, 8'hFF with it. Also a=b=8'hFF -> 8'hC0 without the macro, 8'hFF with it.
- Reset mid-op: assert rst in MUL -> next cycle state IDLE, rsp_valid=0, op_count unchanged (0), ptr=0. A subsequent req2 request is granted normally.

Source files
------------

// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - request/response bundle between multiplier clients and fp_mul_arbiter
interface fp_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_result;
  logic              busy;
  logic [15:0]       op_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, busy, op_count
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one Q5.3 multiplier among NREQ clients
// Define FP_MUL_SAT_EN to saturate overflowing products to 8'hFF instead of wrapping.
module fp_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic            clk,
  input logic            rst,
  fp_mul_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [7:0]      a_r;
  logic [7:0]      b_r;
  logic [7:0]      res_r;
  logic            rsp_valid_r;
  logic [15:0]     op_cnt;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_id;
  logic [IDW:0]    idx;
  logic [NREQ-1:0] ready;
  logic [15:0]     prod;
  logic [7:0]      res_next;
  logic            take;

  // Rotating priority search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (!gnt_found && bus.req_valid[idx[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state == S_IDLE && !rst && gnt_found)
      ready[gnt_id] = 1'b1;
  end

  assign take = |(bus.req_valid & ready);

  // Round half up at the 1/16 bit.
  always_comb begin
    prod     = {8'd0, a_r} * {8'd0, b_r};
    res_next = prod[10:3] + {7'd0, prod[2]};
`ifdef FP_MUL_SAT_EN
    if (prod[15:11] != 5'd0 || (prod[10:3] == 8'hFF && prod[2]))
      res_next = 8'hFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      id_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      rsp_id_r    <= '0;
      res_r       <= '0;
      rsp_valid_r <= 1'b0;
      op_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            a_r   <= bus.req_a[{gnt_id, 3'b000} +: 8];
            b_r   <= bus.req_b[{gnt_id, 3'b000} +: 8];
            id_r  <= gnt_id;
            ptr   <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          res_r       <= res_next;
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            op_cnt      <= op_cnt + 16'd1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = res_r;
  assign bus.busy       = (state != S_IDLE);
  assign bus.op_count   = op_cnt;
endmodule
